// File: rtl/ram_bus_master.sv
// ram_bus_master: RISC-V load/store initiator for the simulation RAM bus, sub-word stores via read-modify-write.
// Define RAM_TIMEOUT_EN to abort a bus phase after TIMEOUT_CYCLES cs-high cycles without ready.
module ram_bus_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        cs,
    output logic        rd,
    output logic        wr,
    output logic [31:0] address,
    output logic [31:0] DB_w,
    input  logic [31:0] DB_r,
    input  logic        ready
);
    typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, GAP, RMW_WR, RESP} state_t;
    state_t state, state_d;
    logic [31:0] addr_q, wdata_q, word_q, mask, merged, lane_w, ld;
    logic [2:0]  f3_q;
    logic [4:0]  sh;
    logic        we_q, err_q, bad, bus, accept, timeout;

    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign bad = (req_we ? (req_funct3[2] | &req_funct3[1:0]) : (&req_funct3[1:0] | &req_funct3[2:1]))
               | (req_funct3[1:0] == 2'b01 & req_addr[0])
               | (req_funct3[1:0] == 2'b10 & |req_addr[1:0]);
    assign accept = req_valid & (state == IDLE);
    assign bus = state == RD | state == WR | state == RMW_RD | state == RMW_WR;

`ifdef RAM_TIMEOUT_EN
    logic [31:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else cnt <= (bus && state_d == state) ? cnt + 32'd1 : '0;
    end
    assign timeout = bus & (cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // Lane shift serves both the load extraction and the store merge.
    assign sh = {addr_q[1:0], 3'b000};
    assign lane_w = word_q >> sh;
    assign mask = (f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
    assign merged = (word_q & ~mask) | ((wdata_q << sh) & mask);
    assign ld = f3_q[1] ? lane_w
              : f3_q[0] ? {{16{lane_w[15] & ~f3_q[2]}}, lane_w[15:0]}
              : {{24{lane_w[7] & ~f3_q[2]}}, lane_w[7:0]};

    always_comb begin
        state_d = state;
        req_ready = state == IDLE;
        cs = bus;
        rd = state == RD | state == RMW_RD;
        wr = state == WR | state == RMW_WR;
        address = bus ? {2'b00, addr_q[31:2]} : '0;
        DB_w = wr ? word_q : '0;
        resp_valid = state == RESP;
        resp_err = resp_valid & err_q;
        resp_rdata = (resp_valid & ~err_q & ~we_q) ? ld : '0;
        case (state)
            IDLE:    if (req_valid) state_d = bad ? RESP : !req_we ? RD : req_funct3[1] ? WR : RMW_RD;
            RD, WR, RMW_WR: if (ready | timeout) state_d = RESP;
            RMW_RD:  state_d = ready ? GAP : timeout ? RESP : RMW_RD;
            GAP:     state_d = RMW_WR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            addr_q <= '0;
            wdata_q <= '0;
            word_q <= '0;
            f3_q <= '0;
            we_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_d;
            if (accept) begin
                addr_q <= req_addr;
                wdata_q <= req_wdata;
                word_q <= req_wdata;
                f3_q <= req_funct3;
                we_q <= req_we;
                err_q <= bad;
            end else if ((state == RD | state == RMW_RD) & ready) word_q <= DB_r;
            else if (state == GAP) word_q <= merged;
            if (bus & ~ready & timeout) err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ram_bus_master.sv
// tb_ram_bus_master: directed checks of ram_bus_master against a 4-cycle-ready RAM model.
module tb_ram_bus_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic        req_ready, resp_valid, resp_err, cs, rd, wr, ready;
    logic [31:0] resp_rdata, address, DB_w, DB_r;
    logic [31:0] mem [16] = '{32'h80FF7F01, 32'h11223344, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [2:0]  ccnt = '0;
    logic        hold_low = 1'b0;
    int n_cmp = 0, n_err = 0;

    ram_bus_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .cs(cs), .rd(rd), .wr(wr), .address(address), .DB_w(DB_w), .DB_r(DB_r), .ready(ready)
    );

    always #5 clk = ~clk;

    // RAM: ready in the 4th consecutive cs-high cycle, counter clears whenever cs is low
    assign ready = cs & (ccnt == 3'd3) & ~hold_low;
    assign DB_r = mem[address[3:0]];
    always @(posedge clk) begin
        ccnt <= cs ? ((ccnt == 3'd7) ? ccnt : ccnt + 3'd1) : 3'd0;
        if (cs & wr & ready) mem[address[3:0]] <= DB_w;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                       output int rc, output int csn, output int gaps, output logic [31:0] rdat,
                       output logic er, output logic [31:0] adr, output int viol);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_funct3 = f3;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rc = 0; csn = 0; gaps = 0; viol = 0; adr = '0; rdat = '0; er = 1'b0;
        for (int n = 1; n <= 40 && rc == 0; n++) begin
            @(negedge clk);
            if (cs) begin csn++; adr = address; end
            else if (csn > 0 && !resp_valid) gaps++;
            if ((rd & wr) | ((rd | wr) & ~cs) | (~cs & (address != 0 | DB_w != 0)) | req_ready) viol++;
            if (resp_valid) begin rc = n; rdat = resp_rdata; er = resp_err; end
        end
    endtask

    typedef struct { logic [31:0] a; logic [2:0] f3; logic [31:0] exp; } ld_vec_t;
    typedef struct { logic we; logic [31:0] a; logic [2:0] f3; } err_vec_t;
    ld_vec_t ld_tab [6] = '{
        '{32'h1, 3'b000, 32'h0000007F}, '{32'h2, 3'b000, 32'hFFFFFFFF}, '{32'h3, 3'b100, 32'h00000080},
        '{32'h2, 3'b001, 32'hFFFF80FF}, '{32'h2, 3'b101, 32'h000080FF}, '{32'h0, 3'b001, 32'h00007F01}};
    err_vec_t err_tab [3] = '{'{1'b0, 32'h2, 3'b010}, '{1'b1, 32'h1, 3'b001}, '{1'b1, 32'h0, 3'b100}};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc, csn, gaps, viol;
        logic [31:0] rdat, adr;
        logic er, rv_seen;
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_cs_rd_wr", {cs, rd, wr}, 0);
        check("rst_address", address, 0);
        check("rst_db_w", DB_w, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", req_ready, 1);

        txn(1'b1, 32'h8, 32'hDEADBEEF, 3'b010, rc, csn, gaps, rdat, er, adr, viol);
        check("sw_resp_cycle", rc, 5);
        check("sw_cs_cycles", csn, 4);
        check("sw_address", adr, 2);
        check("sw_err", er, 0);
        check("sw_mem", mem[2], 32'hDEADBEEF);
        check("sw_bus_rules", viol, 0);

        txn(1'b0, 32'h8, 32'h0, 3'b010, rc, csn, gaps, rdat, er, adr, viol);
        check("lw_resp_cycle", rc, 5);
        check("lw_cs_cycles", csn, 4);
        check("lw_address", adr, 2);
        check("lw_rdata", rdat, 32'hDEADBEEF);
        check("lw_err", er, 0);

        txn(1'b1, 32'h5, 32'h000000AA, 3'b000, rc, csn, gaps, rdat, er, adr, viol);
        check("sb_resp_cycle", rc, 10);
        check("sb_cs_cycles", csn, 8);
        check("sb_gap", gaps, 1);
        check("sb_mem", mem[1], 32'h1122AA44);
        check("sb_bus_rules", viol, 0);
        txn(1'b0, 32'h4, 32'h0, 3'b010, rc, csn, gaps, rdat, er, adr, viol);
        check("sb_readback", rdat, 32'h1122AA44);

        foreach (ld_tab[i]) begin
            txn(1'b0, ld_tab[i].a, 32'h0, ld_tab[i].f3, rc, csn, gaps, rdat, er, adr, viol);
            check($sformatf("load%0d_rdata", i), rdat, ld_tab[i].exp);
        end

        foreach (err_tab[i]) begin
            txn(err_tab[i].we, err_tab[i].a, 32'h12345678, err_tab[i].f3, rc, csn, gaps, rdat, er, adr, viol);
            check($sformatf("err%0d_resp_cycle", i), rc, 1);
            check($sformatf("err%0d_flag", i), er, 1);
            check($sformatf("err%0d_cs_cycles", i), csn, 0);
            check($sformatf("err%0d_rdata", i), rdat, 0);
        end

        txn(1'b1, 32'h6, 32'h0000BEEF, 3'b001, rc, csn, gaps, rdat, er, adr, viol);
        check("sh_resp_cycle", rc, 10);
        check("sh_mem", mem[1], 32'hBEEFAA44);

        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h5; req_wdata = 32'h55; req_funct3 = 3'b000;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_cs_before", cs, 1);
        rst = 1'b1;
        #1;
        check("abort_cs_rd", {cs, rd}, 0);
        check("abort_req_ready", req_ready, 1);
        rv_seen = 1'b0;
        repeat (3) begin @(negedge clk); rv_seen |= resp_valid; end
        rst = 1'b0;
        repeat (12) begin @(negedge clk); rv_seen |= resp_valid; end
        check("abort_no_resp", rv_seen, 0);
        check("abort_mem", mem[1], 32'hBEEFAA44);

        hold_low = 1'b1;
        txn(1'b0, 32'h0, 32'h0, 3'b010, rc, csn, gaps, rdat, er, adr, viol);
`ifdef RAM_TIMEOUT_EN
        check("to_resp_cycle", rc, 17);
        check("to_cs_cycles", csn, 16);
        check("to_err", er, 1);
        check("to_rdata", rdat, 0);
`else
        check("hang_no_resp", rc, 0);
        check("hang_cs_cycles", csn, 40);
        check("hang_cs_high", cs, 1);
`endif
        @(negedge clk);
        rst = 1'b1;
        hold_low = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        txn(1'b0, 32'h0, 32'h0, 3'b010, rc, csn, gaps, rdat, er, adr, viol);
        check("recover_rdata", rdat, 32'h80FF7F01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ram_bus_master.md
# ram_bus_master

Core-side initiator for the simulation RAM bus (`cs`/`rd`/`wr`/`address`/`DB_w`/`DB_r`/`ready`). It accepts one RISC-V load/store request at a time from the core's memory stage. It converts the byte address to a word address and runs the bus cycle until the RAM raises `ready`. Sub-word stores are done as a read-modify-write, and load data comes back byte/halfword-extracted and sign- or zero-extended.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: maximum `cs`-high cycles per bus phase before abort. Used only with `RAM_TIMEOUT_EN`.

Ports:
- `clk`  in  1  — clock; all state changes on the rising edge.
- `rst`  in  1  — reset; asynchronous, active-high.
- `req_valid`  in  1  — request present.
- `req_ready`  out  1  — high only in IDLE; a request is accepted on an edge where `req_valid & req_ready`.
- `req_we`  in  1  — 1 = store, 0 = load.
- `req_addr`  in  32  — byte address.
- `req_wdata`  in  32  — store data, right-aligned.
- `req_funct3`  in  3  — size code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only).
- `resp_valid`  out  1  — one-cycle completion pulse; there is no backpressure.
- `resp_rdata`  out  32  — load result; 0 for stores and errors.
- `resp_err`  out  1  — qualifies `resp_valid`. Set on misaligned access, illegal size, or timeout.
- `cs`, `rd`, `wr`  out  1  — RAM select, read strobe, write strobe.
- `address`  out  32  — word address, `{2'b00, addr[31:2]}`.
- `DB_w`  out  32  — write data.
- `DB_r`  in  32  — read data.
- `ready`  in  1  — RAM completion.

## Operation
- States: IDLE, RD, WR, RMW_RD, GAP, RMW_WR, RESP.
- IDLE:
  - `req_ready`=1.
  - On accept, latch the request, then check it:
    - Illegal size (store funct3 ∉ {000,001,010}; load funct3 ∈ {011,110,111}) → RESP with error, no bus cycle.
    - Misaligned (H with addr[0]=1; W with addr[1:0]≠0) → RESP with error, no bus cycle.
    - Otherwise: load or SW → RD or WR respectively; SB/SH → RMW_RD.
- RD / RMW_RD: `cs`=1, `rd`=1, `wr`=0. Capture `DB_r` on the edge where `ready`=1.
  - RD → RESP.
  - RMW_RD → GAP.
- GAP:
  - One cycle with `cs`=0, so the RAM's ready counter clears.
  - Compute the merged word: byte/halfword of `req_wdata` placed at lane `addr[1:0]` of the captured word.
  - → RMW_WR.
- WR / RMW_WR: `cs`=1, `wr`=1, `rd`=0, `DB_w` = store word. On `ready` → RESP.
- RESP:
  - `resp_valid`=1 for exactly one cycle; `cs`=0.
  - Load data is extracted by lane, then sign-extended (B/H) or zero-extended (BU/HU).
  - → IDLE.
- `rd` and `wr` are never high together, and neither is high while `cs`=0.
- `address` and `DB_w` are 0 whenever `cs`=0.
- A request presented while busy is held off (`req_ready`=0); it is never dropped and never queued.
- `rst` asserted in any state → IDLE immediately. No response is issued for the aborted request.

## Timing
- Reset values: `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `cs`=`rd`=`wr`=0, `address`=0, `DB_w`=0.
- The RAM raises `ready` in the 4th consecutive `cs`-high cycle. Each bus phase therefore holds `cs` for 4 cycles (C1..C4).
- Counted from the acceptance edge:
  - LW/SW/LB/LH: `cs` high for cycles 1–4, `resp_valid` in cycle 5; next accept possible at the end of cycle 6.
  - SB/SH: read phase cycles 1–4, GAP cycle 5, write phase cycles 6–9, `resp_valid` in cycle 10.
  - Error requests: `resp_valid` in cycle 1, with zero bus activity.
- `cs` always drops for at least one cycle between bus phases (via GAP or RESP→IDLE).

## Configuration
- `RAM_TIMEOUT_EN` defined:
  - A per-phase counter counts `cs`-high cycles and resets on phase entry.
  - If it reaches `TIMEOUT_CYCLES` without `ready`, drop `cs` and go to RESP with `resp_err`=1 and `resp_rdata`=0. A timed-out RMW read skips its write phase.
- Not defined: no counter; the block waits for `ready` indefinitely.

## Test plan
- LW from 0x8 after storing 0xDEADBEEF with SW to 0x8 → `address`=2 both times; `cs` high exactly 4 cycles per access; `resp_rdata`=0xDEADBEEF, `resp_err`=0, `resp_valid` 5 cycles after accept.
- Word at 0x4 = 0x11223344; SB 0xAA to 0x5, then LW 0x4 → one cycle with `cs`=0 between the read and write phases; word reads back 0x1122AA44.
- Word 0x80FF7F01 at 0x0: LB 0x1 → 0x0000007F; LB 0x2 → 0xFFFFFFFF; LBU 0x3 → 0x00000080; LH 0x2 → 0xFFFF80FF; LHU 0x2 → 0x000080FF.
- LW 0x2, SH 0x1, store with funct3=100 → each gives `resp_err`=1 one cycle after accept; `cs` never rises.
- Assert `rst` in cycle 2 of an SB's read phase → `cs`/`rd` fall immediately, no `resp_valid`, memory unchanged, `req_ready`=1.
- With `RAM_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, tie `ready`=0 → `cs` high 16 cycles, then `resp_valid` with `resp_err`=1; without the macro, `cs` stays high and no response is issued.
